// File: rtl/mi_reg_responder.sv
// MI slave endpoint: byte-enabled register file with fixed-latency in-order read return.
// Optional error counter port ERR_CNT is enabled by defining MI_RESP_ERR_CNT_EN.
module mi_reg_responder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned META_WIDTH   = 2,
  parameter int unsigned REGS         = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [DATA_WIDTH-1:0]   MI_DWR,
  input  logic [META_WIDTH-1:0]   MI_MWR,
  input  logic [ADDR_WIDTH-1:0]   MI_ADDR,
  input  logic [DATA_WIDTH/8-1:0] MI_BE,
  input  logic                    MI_RD,
  input  logic                    MI_WR,
  output logic                    MI_ARDY,
  output logic [DATA_WIDTH-1:0]   MI_DRD,
`ifdef MI_RESP_ERR_CNT_EN
  output logic [15:0]             ERR_CNT,
`endif
  output logic                    MI_DRDY
);

  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(BE_W);
  localparam int unsigned IDX_W   = $clog2(REGS);
  localparam int unsigned SPAN    = REGS * BE_W;
  localparam int unsigned STALL_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

  logic [DATA_WIDTH-1:0] regs_q [REGS];
  logic                  vld_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] dat_q  [READ_LATENCY];
  logic [STALL_W-1:0]    stall_q;

  logic [ADDR_WIDTH-1:0] offset_c;
  logic                  in_range_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  req_c;
  logic                  acc_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  unused_ok;

  // Metadata travels with the request but carries no meaning here.
  assign unused_ok = ^MI_MWR;

  // Address decode: wrap-around subtraction makes addresses below the base out of range.
  assign offset_c   = MI_ADDR - BASE_ADDR;
  assign in_range_c = offset_c < ADDR_WIDTH'(SPAN);
  assign idx_c      = MI_ADDR[OFF_W+IDX_W-1:OFF_W];

  assign req_c    = MI_RD | MI_WR;
  assign MI_ARDY  = req_c & ~RESET & (stall_q == '0);
  assign acc_c    = req_c & MI_ARDY;
  assign wr_acc_c = acc_c & MI_WR;
  assign rd_acc_c = acc_c & MI_RD & ~MI_WR;
  assign rdata_c  = in_range_c ? regs_q[idx_c] : '0;

  // Post-accept throttle counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (acc_c) begin
      stall_q <= STALL_W'(STALL_CYCLES);
    end else if (stall_q != '0) begin
      stall_q <= stall_q - STALL_W'(1);
    end
  end

  // Register file with per-byte write enables.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned r = 0; r < REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_acc_c && in_range_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (MI_BE[b]) begin
          regs_q[idx_c][b*8 +: 8] <= MI_DWR[b*8 +: 8];
        end
      end
    end
  end

  // Fixed-latency read return pipeline; reset drops anything in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc_c;
      dat_q[0] <= rd_acc_c ? rdata_c : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign MI_DRDY = vld_q[READ_LATENCY-1];
  assign MI_DRD  = dat_q[READ_LATENCY-1];

`ifdef MI_RESP_ERR_CNT_EN
  logic [15:0] err_q;

  // Saturating count of out-of-range and RD+WR collision accesses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= '0;
    end else if (acc_c && (!in_range_c || (MI_RD && MI_WR)) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign ERR_CNT = err_q;
`endif

endmodule

// File: tb/tb_mi_reg_responder.sv
// Bench for mi_reg_responder: two configurations driven by directed and random MI traffic,
// checked each cycle against a calendar-based behavioural model.
module tb_mi_reg_responder;

  localparam int L0 = 2, S0 = 0, N0 = 16;
  localparam int L1 = 3, S1 = 2, N1 = 8;
  localparam logic [31:0] B0 = 32'h0, B1 = 32'h100;

  logic        clk = 1'b0;
  logic        rst_r;
  logic        rd_r   [2];
  logic        wr_r   [2];
  logic [31:0] addr_r [2];
  logic [31:0] dwr_r  [2];
  logic [3:0]  be_r   [2];
  logic [1:0]  mwr_r;
  logic        ardy_w [2];
  logic        drdy_w [2];
  logic [31:0] drd_w  [2];
`ifdef MI_RESP_ERR_CNT_EN
  logic [15:0] err_w  [2];
`endif

  always #5 clk = ~clk;

  mi_reg_responder #(.READ_LATENCY(L0), .STALL_CYCLES(S0), .REGS(N0), .BASE_ADDR(B0)) dut0 (
    .CLK(clk), .RESET(rst_r), .MI_DWR(dwr_r[0]), .MI_MWR(mwr_r), .MI_ADDR(addr_r[0]),
    .MI_BE(be_r[0]), .MI_RD(rd_r[0]), .MI_WR(wr_r[0]), .MI_ARDY(ardy_w[0]),
    .MI_DRD(drd_w[0]),
`ifdef MI_RESP_ERR_CNT_EN
    .ERR_CNT(err_w[0]),
`endif
    .MI_DRDY(drdy_w[0]));

  mi_reg_responder #(.READ_LATENCY(L1), .STALL_CYCLES(S1), .REGS(N1), .BASE_ADDR(B1)) dut1 (
    .CLK(clk), .RESET(rst_r), .MI_DWR(dwr_r[1]), .MI_MWR(mwr_r), .MI_ADDR(addr_r[1]),
    .MI_BE(be_r[1]), .MI_RD(rd_r[1]), .MI_WR(wr_r[1]), .MI_ARDY(ardy_w[1]),
    .MI_DRD(drd_w[1]),
`ifdef MI_RESP_ERR_CNT_EN
    .ERR_CNT(err_w[1]),
`endif
    .MI_DRDY(drdy_w[1]));

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] mem   [2][16];
  bit          cal_v [2][8];
  logic [31:0] cal_d [2][8];
  int          stl_m [2];
  logic [15:0] err_m [2];
  bit          accepted [2];
  int          n_drdy [2];
  int          n_acc  [2];
  logic [7:0]  ardy_hist [2];
  logic [31:0] cap0 [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int k);  return (k == 0) ? L0 : L1; endfunction
  function automatic int stl_of(input int k);  return (k == 0) ? S0 : S1; endfunction
  function automatic int nreg_of(input int k); return (k == 0) ? N0 : N1; endfunction
  function automatic logic [31:0] base_of(input int k); return (k == 0) ? B0 : B1; endfunction

  // One cycle of reference behaviour for instance k, checked before the clock edge.
  task automatic model_cycle(input int k);
    bit          req, ardy_e, inr;
    int          slot, idx;
    logic [31:0] off, d;
    req    = rd_r[k] | wr_r[k];
    ardy_e = req && !rst_r && (stl_m[k] == 0);
    slot   = cyc % 8;
    accepted[k] = 1'b0;
    chk($sformatf("ardy%0d", k), 32'(ardy_w[k]), 32'(ardy_e));
    if (!rst_r) begin
      chk($sformatf("drdy%0d", k), 32'(drdy_w[k]), 32'(cal_v[k][slot]));
      if (cal_v[k][slot]) chk($sformatf("drd%0d", k), drd_w[k], cal_d[k][slot]);
`ifdef MI_RESP_ERR_CNT_EN
      chk($sformatf("err_cnt%0d", k), 32'(err_w[k]), 32'(err_m[k]));
`endif
    end
    if (drdy_w[k]) begin
      n_drdy[k]++;
      if (k == 0) cap0.push_back(drd_w[0]);
    end
    ardy_hist[k] = {ardy_hist[k][6:0], ardy_w[k]};
    cal_v[k][slot] = 1'b0;
    if (rst_r) begin
      for (int i = 0; i < 16; i++) mem[k][i] = '0;
      for (int i = 0; i < 8; i++) cal_v[k][i] = 1'b0;
      stl_m[k] = 0;
      err_m[k] = '0;
    end else if (ardy_e) begin
      accepted[k] = 1'b1;
      n_acc[k]++;
      off = addr_r[k] - base_of(k);
      inr = off < 32'(nreg_of(k) * 4);
      idx = int'(off / 4);
      if (wr_r[k]) begin
        if (inr)
          for (int b = 0; b < 4; b++)
            if (be_r[k][b]) mem[k][idx][8*b +: 8] = dwr_r[k][8*b +: 8];
      end else begin
        d = inr ? mem[k][idx] : 32'h0;
        cal_v[k][(cyc + lat_of(k)) % 8] = 1'b1;
        cal_d[k][(cyc + lat_of(k)) % 8] = d;
      end
      if ((!inr || (rd_r[k] && wr_r[k])) && err_m[k] != 16'hFFFF) err_m[k] = err_m[k] + 16'd1;
      stl_m[k] = stl_of(k);
    end else if (stl_m[k] > 0) begin
      stl_m[k] = stl_m[k] - 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_cycle(k);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int n;
    rd_r[k] = rd; wr_r[k] = wr; addr_r[k] = a; dwr_r[k] = d; be_r[k] = be;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted[k] && n < 20);
    chk("accept_bound", 32'(accepted[k]), 32'd1);
    rd_r[k] = 1'b0; wr_r[k] = 1'b0;
  endtask

  initial begin
    int snap, snap_acc;
    mwr_r = 2'b00;
    for (int k = 0; k < 2; k++) begin
      rd_r[k] = 0; wr_r[k] = 0; addr_r[k] = '0; dwr_r[k] = '0; be_r[k] = '0;
      stl_m[k] = 0; err_m[k] = '0; n_drdy[k] = 0; n_acc[k] = 0; ardy_hist[k] = '0;
      for (int i = 0; i < 8; i++) begin cal_v[k][i] = 0; cal_d[k][i] = '0; end
      for (int i = 0; i < 16; i++) mem[k][i] = '0;
    end
    @(posedge clk); #1;
    rst_r = 1'b1;
    idle(2);
    rst_r = 1'b0;
    idle(1);
    chk("rst_drd", drd_w[0], 32'h0);
    chk("rst_drdy", 32'(drdy_w[1]), 32'h0);

    // Write then immediate read-back.
    cap0.delete();
    issue(0, 0, 1, 32'h08, 32'hA5A5_1234, 4'hF);
    issue(0, 1, 0, 32'h08, 32'h0, 4'h0);
    idle(3);
    chk("wr_rd_cnt", 32'(cap0.size()), 32'd1);
    if (cap0.size() > 0) chk("wr_rd_data", cap0[0], 32'hA5A5_1234);

    // Partial byte write.
    cap0.delete();
    issue(0, 0, 1, 32'h0C, 32'h1122_3344, 4'hF);
    issue(0, 0, 1, 32'h0F, 32'hFFFF_FFFF, 4'b0101);
    issue(0, 1, 0, 32'h0C, 32'h0, 4'h0);
    idle(3);
    if (cap0.size() > 0) chk("be_merge", cap0[0], 32'h11FF_33FF);

    // Back-to-back reads of preloaded registers.
    for (int i = 0; i < 4; i++) issue(0, 0, 1, 32'(i * 4), 32'(i), 4'hF);
    cap0.delete();
    for (int i = 0; i < 4; i++) issue(0, 1, 0, 32'(i * 4), 32'h0, 4'h0);
    idle(3);
    chk("b2b_cnt", 32'(cap0.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap0.size(); i++) chk($sformatf("b2b_%0d", i), cap0[i], 32'(i));

    // Continuous read against the stalling instance.
    snap = n_drdy[1]; snap_acc = n_acc[1];
    rd_r[1] = 1'b1; addr_r[1] = B1 + 32'h4;
    idle(6);
    rd_r[1] = 1'b0;
    chk("stall_pattern", 32'(ardy_hist[1][5:0]), 32'b100100);
    idle(6);
    chk("stall_acc", 32'(n_acc[1] - snap_acc), 32'd2);
    chk("stall_drdy", 32'(n_drdy[1] - snap), 32'(n_acc[1] - snap_acc));

    // Out-of-range and collision.
    cap0.delete();
    issue(0, 1, 0, 32'h40, 32'h0, 4'h0);
    issue(0, 0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    issue(0, 1, 0, 32'h00, 32'h0, 4'h0);
    idle(3);
    chk("oor_cnt", 32'(cap0.size()), 32'd2);
    if (cap0.size() > 1) begin
      chk("oor_read", cap0[0], 32'h0);
      chk("oor_write", cap0[1], 32'h0);
    end
    snap = n_drdy[0];
    issue(0, 1, 1, 32'h10, 32'h0000_0055, 4'hF);
    idle(4);
    chk("coll_nodrdy", 32'(n_drdy[0] - snap), 32'd0);
    cap0.delete();
    issue(0, 1, 0, 32'h10, 32'h0, 4'h0);
    idle(3);
    if (cap0.size() > 0) chk("coll_write", cap0[0], 32'h0000_0055);
`ifdef MI_RESP_ERR_CNT_EN
    chk("err_cnt_total", 32'(err_w[0]), 32'd3);
`endif

    // Reset one cycle after a read is accepted.
    snap = n_drdy[0];
    issue(0, 1, 0, 32'h08, 32'h0, 4'h0);
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    idle(5);
    chk("rst_flight", 32'(n_drdy[0] - snap), 32'd0);
    cap0.delete();
    for (int i = 0; i < 16; i++) issue(0, 1, 0, 32'(i * 4), 32'h0, 4'h0);
    idle(3);
    chk("rst_regs_cnt", 32'(cap0.size()), 32'd16);
    if (cap0.size() > 3) chk("rst_reg2", cap0[2] | cap0[3], 32'h0);

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!rd_r[k] && !wr_r[k] && $urandom_range(0, 2) != 0) begin
          int t, r;
          t = $urandom_range(0, 9);
          r = $urandom_range(0, 9);
          rd_r[k] = (t <= 4) || (t == 9);
          wr_r[k] = (t >= 5);
          if (r < 8)       addr_r[k] = base_of(k) + 32'($urandom_range(0, nreg_of(k) * 4 - 1));
          else if (r == 8) addr_r[k] = base_of(k) + 32'(nreg_of(k) * 4) + 32'($urandom_range(0, 63));
          else             addr_r[k] = $urandom;
          dwr_r[k] = $urandom;
          be_r[k]  = 4'($urandom_range(0, 15));
        end
      end
      mwr_r = 2'($urandom_range(0, 3));
      rst_r = ($urandom_range(0, 299) == 0);
      step();
      for (int k = 0; k < 2; k++)
        if (accepted[k]) begin rd_r[k] = 1'b0; wr_r[k] = 1'b0; end
    end
    rst_r = 1'b0;
    for (int k = 0; k < 2; k++) begin rd_r[k] = 1'b0; wr_r[k] = 1'b0; end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mi_reg_responder.md
Name: mi_reg_responder

Overview:
- MI slave endpoint that terminates the MI bus at the far end of an MI pipe or interconnect.
- Accepts read and write requests under ARDY handshaking and stores data in a small byte-enabled register file.
- Returns read data in order after a fixed, parameterised latency, with optional ARDY throttling.
- Serves as the responder model and lightweight register block for MI tools and their verification environments.

Parameters:
DATA_WIDTH, 32, MI data width in bits; multiple of 8.
ADDR_WIDTH, 32, MI address width in bits.
META_WIDTH, 2, MI metadata width; accepted and ignored.
REGS, 16, number of DATA_WIDTH registers; power of two, at least 2.
BASE_ADDR, 0, byte address of register 0; aligned to REGS*DATA_WIDTH/8.
READ_LATENCY, 2, cycles from read acceptance to DRDY; at least 1.
STALL_CYCLES, 0, ARDY low cycles after each accepted request; 0 means no stall.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-high
MI_DWR  in  DATA_WIDTH  write data
MI_MWR  in  META_WIDTH  write metadata (ignored)
MI_ADDR  in  ADDR_WIDTH  byte address
MI_BE  in  DATA_WIDTH/8  byte enables
MI_RD  in  1  read request
MI_WR  in  1  write request
MI_ARDY  out  1  request accepted this cycle
MI_DRD  out  DATA_WIDTH  read data
MI_DRDY  out  1  read data valid

Behaviour:
- Accept = (MI_RD or MI_WR) and MI_ARDY. The master holds a request until it is accepted.
- MI_ARDY is combinational: (MI_RD or MI_WR) and not RESET and stall_cnt = 0.
- Register index = MI_ADDR[log2(DW/8)+log2(REGS)-1 : log2(DW/8)].
- An access is in range when (MI_ADDR - BASE_ADDR) < REGS*DW/8. Address LSBs below word alignment are ignored.
- Write on accept, in range: each byte i with MI_BE[i]=1 is updated at that edge; other bytes are kept. Out-of-range writes are dropped but still acknowledged.
- Read on accept: the register value (or 0 if out of range) is sampled at the accept edge. MI_BE is ignored for reads.
  - The sample enters a READ_LATENCY-deep shift pipeline of {valid, data}.
  - MI_DRDY/MI_DRD are driven from the last stage, so DRDY pulses exactly READ_LATENCY cycles after acceptance.
- Ordering and throughput:
  - Read data returns in acceptance order, one DRDY per accepted read.
  - No backpressure on read data; back-to-back reads give back-to-back DRDY.
- Write-then-read: a read accepted the cycle after a write to the same register returns the new data.
- MI_RD and MI_WR both high: treated as a write only; no DRDY is generated.
- Stall counter:
  - On every accept, stall_cnt loads STALL_CYCLES.
  - While nonzero, it decrements each cycle and ARDY is 0.
  - With STALL_CYCLES=0, every request is accepted in the cycle it is presented.
- Reset values: all registers 0, pipeline valid bits 0, stall_cnt 0, MI_DRDY 0, MI_DRD 0, MI_ARDY 0.
- Reset mid-operation: in-flight reads are discarded and no DRDY is issued for them. MI_DRDY is 0 from the first cycle after the reset edge.

Optional Feature:
- Macro: MI_RESP_ERR_CNT_EN.
- When defined:
  - Adds output port ERR_CNT (16 bits, reset 0).
  - ERR_CNT increments by 1 on each accepted out-of-range access and each accepted RD+WR collision.
  - An access that is both out of range and a collision counts once.
  - ERR_CNT saturates at 0xFFFF.
- When undefined: no port and no counter logic. Functional behaviour is otherwise identical.

Test Plan:
- Write and read back: DW=32, REGS=16, BASE=0, LAT=2. Write addr 0x08, BE=1111, data 0xA5A5_1234, then read addr 0x08 the next cycle -> DRDY exactly 2 cycles after read accept with DRD=0xA5A5_1234.
- Byte enables: reg 3 holds 0x1122_3344; write 0xFFFF_FFFF with BE=0101 -> readback 0x11FF_33FF.
- Back-to-back reads: 4 consecutive reads of regs 0..3 (preloaded with 0,1,2,3) -> 4 consecutive DRDY pulses, DRD=0,1,2,3 in order.
- Stall: STALL_CYCLES=2 with continuous RD held -> ARDY pattern 1,0,0,1,0,0; DRDY count equals accept count.
- Out of range and collision:
  - Read addr 0x40 -> DRD=0.
  - Write to 0x40 -> no register changes.
  - RD+WR together -> write performed, no DRDY.
  - With MI_RESP_ERR_CNT_EN, ERR_CNT=3.
- Reset mid-flight: assert RESET 1 cycle after a read accept -> no DRDY is ever produced for that read, and all registers read 0 after reset.
